// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: write-back, multi-cycle result and register-file write port bundle
interface rf_write_arbiter_if #(parameter int DATA_W = 16, parameter int ADDR_W = 3);
   logic                 wb_valid;
   logic [ADDR_W-1:0]    wb_dest;
   logic [DATA_W-1:0]    wb_data;
   logic                 mc_valid;
   logic                 mc_ready;
   logic [ADDR_W-1:0]    mc_dest;
   logic [DATA_W-1:0]    mc_data;
   logic                 rf_we;
   logic [ADDR_W-1:0]    rf_waddr;
   logic [DATA_W-1:0]    rf_wdata;
   logic                 rf_src;
   logic                 stall_req;
   logic [2**ADDR_W-1:0] pend_mask;
   modport master (
      output wb_valid, wb_dest, wb_data, mc_valid, mc_dest, mc_data,
      input  mc_ready, rf_we, rf_waddr, rf_wdata, rf_src, stall_req, pend_mask
   );
   modport slave (
      input  wb_valid, wb_dest, wb_data, mc_valid, mc_dest, mc_data,
      output mc_ready, rf_we, rf_waddr, rf_wdata, rf_src, stall_req, pend_mask
   );
endinterface

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port between WB and a buffered multi-cycle unit
module rf_write_arbiter #(
   parameter int DATA_W       = 16,
   parameter int ADDR_W       = 3,
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input logic           clk,
   input logic           rst,
   rf_write_arbiter_if.slave bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   logic [ADDR_W-1:0] mem_dest [FIFO_DEPTH];
   logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
   logic [PW-1:0]     rd_ptr, wr_ptr;
   logic [CW-1:0]     count, count_next;
   logic [SW-1:0]     starve_cnt, starve_next;
   logic              empty, push, pop, grant_wb, stall_next;
   assign empty       = count == '0;
   assign bus.mc_ready = count != CW'(FIFO_DEPTH);
   assign push        = bus.mc_valid && bus.mc_ready;
   // a pending stall hands the port to the FIFO and masks the held WB request
   assign pop         = !empty && (bus.stall_req || !bus.wb_valid);
   assign grant_wb    = bus.wb_valid && !pop;
   assign count_next  = count + CW'(push) - CW'(pop);
   assign starve_next = (empty || pop) ? '0 :
                        (starve_cnt == SW'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + SW'(1);
   assign stall_next  = (count_next == '0) ? 1'b0 :
                        (starve_next == SW'(STARVE_LIMIT)) ? 1'b1 : bus.stall_req;
   always_comb begin
      bus.pend_mask = '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
         if (i < int'(count)) bus.pend_mask[mem_dest[rd_ptr + PW'(i)]] = 1'b1;
   end
   always_ff @(posedge clk)
      if (push) begin
         mem_dest[wr_ptr] <= bus.mc_dest;
         mem_data[wr_ptr] <= bus.mc_data;
      end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         count         <= '0;
         starve_cnt    <= '0;
         bus.stall_req <= 1'b0;
         bus.rf_we     <= 1'b0;
         bus.rf_waddr  <= '0;
         bus.rf_wdata  <= '0;
         bus.rf_src    <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         count         <= count_next;
         starve_cnt    <= starve_next;
         bus.stall_req <= stall_next;
         bus.rf_we     <= pop || grant_wb;
         bus.rf_waddr  <= pop ? mem_dest[rd_ptr] : grant_wb ? bus.wb_dest : '0;
         bus.rf_wdata  <= pop ? mem_data[rd_ptr] : grant_wb ? bus.wb_data : '0;
         bus.rf_src    <= pop;
      end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: random and directed stimulus against a queue-based reference model
module tb_rf_write_arbiter;
   localparam int DEPTH = 2;
   localparam int LIMIT = 4;
   typedef struct packed {
      logic [2:0]  d;
      logic [15:0] v;
   } ent_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   ent_t q[$];
   bit   m_stall;
   int   m_starve;
   logic e_we, e_src;
   logic [2:0]  e_addr;
   logic [15:0] e_data;
   rf_write_arbiter_if #(.DATA_W(16), .ADDR_W(3)) bus ();
   rf_write_arbiter #(.DATA_W(16), .ADDR_W(3), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask
   function automatic logic [7:0] exp_mask();
      logic [7:0] m = '0;
      foreach (q[i]) m[q[i].d] = 1'b1;
      return m;
   endfunction
   task automatic model_reset();
      q.delete();
      m_stall  = 0;
      m_starve = 0;
      {e_we, e_src, e_addr, e_data} = '0;
   endtask
   task automatic check_all();
      check("rf_we", 32'(bus.rf_we), 32'(e_we));
      check("rf_waddr", 32'(bus.rf_waddr), 32'(e_addr));
      check("rf_wdata", 32'(bus.rf_wdata), 32'(e_data));
      check("rf_src", 32'(bus.rf_src), 32'(e_src));
      check("stall_req", 32'(bus.stall_req), 32'(m_stall));
      check("mc_ready", 32'(bus.mc_ready), 32'(q.size() < DEPTH));
      check("pend_mask", 32'(bus.pend_mask), 32'(exp_mask()));
   endtask
   // drive one cycle of inputs, advance the model, check after the edge
   task automatic step(input logic wv, input logic [2:0] wd, input logic [15:0] wdat,
                       input logic mv, input logic [2:0] md, input logic [15:0] mdat);
      bit was_empty, take_mc, push;
      bus.wb_valid = wv; bus.wb_dest = wd; bus.wb_data = wdat;
      bus.mc_valid = mv; bus.mc_dest = md; bus.mc_data = mdat;
      was_empty = q.size() == 0;
      push      = mv && q.size() < DEPTH;
      take_mc   = !was_empty && (m_stall || !wv);
      e_we      = take_mc || wv;
      e_src     = take_mc;
      e_addr    = take_mc ? q[0].d : wv ? wd : 3'd0;
      e_data    = take_mc ? q[0].v : wv ? wdat : 16'd0;
      if (take_mc) void'(q.pop_front());
      if (push) q.push_back({md, mdat});
      m_starve  = (was_empty || take_mc) ? 0 : (m_starve < LIMIT ? m_starve + 1 : LIMIT);
      m_stall   = q.size() == 0 ? 0 : (m_starve == LIMIT ? 1 : m_stall);
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
   endtask
   logic        r_wv;
   logic [2:0]  r_wd;
   logic [15:0] r_wdat;
   initial begin
      model_reset();
      {bus.wb_valid, bus.wb_dest, bus.wb_data, bus.mc_valid, bus.mc_dest, bus.mc_data} = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_all();
      idle(2);
      step(0, 0, 0, 1, 3'd5, 16'hABCD);
      idle(3);
      step(0, 0, 0, 1, 3'd3, 16'h3333);
      step(1, 3'd2, 16'h0011, 0, 0, 0);
      step(1, 3'd1, 16'h0022, 0, 0, 0);
      idle(2);
      step(1, 3'd6, 16'h0100, 1, 3'd7, 16'h7777);
      for (int i = 0; i < 8; i++) step(1, 3'd6, 16'h0100 + 16'(i), 0, 0, 0);
      idle(2);
      step(1, 3'd1, 16'h1000, 1, 3'd1, 16'hA001);
      step(1, 3'd1, 16'h1001, 1, 3'd2, 16'hA002);
      step(1, 3'd1, 16'h1002, 1, 3'd3, 16'hA003);
      step(0, 0, 0, 1, 3'd4, 16'hA004);
      idle(4);
      step(1, 3'd0, 16'h0, 1, 3'd4, 16'hB001);
      step(1, 3'd0, 16'h0, 1, 3'd4, 16'hB002);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      idle(2);
      r_wv = 0; r_wd = 0; r_wdat = 0;
      for (int i = 0; i < 3000; i++) begin
         if (!m_stall) begin
            r_wv   = $urandom_range(0, 9) < 7;
            r_wd   = 3'($urandom);
            r_wdat = 16'($urandom);
         end
         step(r_wv, r_wd, r_wdat, $urandom_range(0, 9) < 4, 3'($urandom), 16'($urandom));
      end
      step(1, 3'd2, 16'h5, 1, 3'd6, 16'hC001);
      step(1, 3'd2, 16'h5, 1, 3'd7, 16'hC002);
      #2 rst = 1'b1;
      model_reset();
      #1 check_all();
      @(negedge clk);
      rst = 1'b0;
      check_all();
      idle(6);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
